// File: rtl/vga_mem_arbiter.sv
// Arbitrates one memory port between a VGA fetch engine and a CPU, with a
// starvation guard for the CPU and a frame-synchronised display offset register.
module vga_mem_arbiter #(
   parameter int          VGA_MAX_RUN = 4,
   parameter logic [19:0] OFFSET_ADDR = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vga_sel,
   input  logic [19:0] vga_addr,
   output logic [47:0] vga_data,
   output logic        vga_valid,
   input  logic        vga_offset_sel,
   output logic [19:0] vga_offset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [19:0] cpu_addr,
   input  logic [47:0] cpu_wdata,
   output logic [47:0] cpu_rdata,
   output logic        cpu_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [47:0] mem_wdata,
   input  logic [47:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  dbg_state
);

   // Handshake: mem_req rises the cycle after a grant and holds a stable
   // payload until the cycle mem_ack=1; requesters see a one-cycle pulse next.
   typedef enum logic [1:0] {IDLE, VGA_XFER, CPU_XFER, CPU_REG} state_t;

   localparam int RW = $clog2(VGA_MAX_RUN + 1);
   localparam logic [RW-1:0] RUN_MAX = RW'(VGA_MAX_RUN);

   state_t        state, next_state;
   logic [RW-1:0] run_cnt;
   logic [19:0]   offset_shadow;
   logic          grant_vga, grant_cpu, cpu_is_reg;

   assign dbg_state  = state;
   assign cpu_is_reg = (cpu_addr == OFFSET_ADDR);

   always_comb begin
      next_state = state;
      grant_vga  = 1'b0;
      grant_cpu  = 1'b0;
      case (state)
         IDLE: begin
            // No arbitration while a completion pulse is still visible.
            if (!(vga_valid || cpu_ack)) begin
               if (vga_sel && (run_cnt < RUN_MAX)) grant_vga = 1'b1;
               else if (cpu_req)                   grant_cpu = 1'b1;
               else if (vga_sel)                   grant_vga = 1'b1;
            end
            if (grant_vga)      next_state = VGA_XFER;
            else if (grant_cpu) next_state = cpu_is_reg ? CPU_REG : CPU_XFER;
         end
         VGA_XFER, CPU_XFER: if (mem_ack) next_state = IDLE;
         CPU_REG:            next_state = IDLE;
         default:            next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt <= '0;
      end else if (grant_cpu) begin
         run_cnt <= '0;
      end else if (grant_vga && cpu_req) begin
         if (run_cnt < RUN_MAX) run_cnt <= run_cnt + 1'b1;
      end else if (state == IDLE && !cpu_req) begin
         run_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_shadow <= '0;
         vga_offset    <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         vga_valid     <= 1'b0;
         vga_data      <= '0;
         cpu_ack       <= 1'b0;
         cpu_rdata     <= '0;
      end else begin
         vga_valid <= 1'b0;
         cpu_ack   <= 1'b0;
         // Samples the shadow before any same-cycle register write lands.
         if (vga_offset_sel) vga_offset <= offset_shadow;

         if (grant_vga) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= vga_addr;
            mem_wdata <= '0;
         end else if (grant_cpu && !cpu_is_reg) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
         end else if (grant_cpu) begin
            if (cpu_we) offset_shadow <= cpu_wdata[19:0];
            else        cpu_rdata     <= {28'b0, offset_shadow};
            cpu_ack <= 1'b1;
         end

         if (state == VGA_XFER && mem_ack) begin
            mem_req   <= 1'b0;
            vga_data  <= mem_rdata;
            vga_valid <= 1'b1;
         end
         if (state == CPU_XFER && mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_rdata <= mem_rdata;
            cpu_ack <= 1'b1;
         end
      end
   end

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter VGA_MAX_RUN, default 4: maximum consecutive VGA grants while a CPU request is pending.
REQ-002 SHALL have parameter OFFSET_ADDR, default 20'hFFFFF: CPU address of the frame-offset register, never forwarded to memory.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports vga_sel, input, 1 (VGA fetch request, level) and vga_addr, input, 20 (VGA fetch address).
REQ-006 SHALL have ports vga_data, output, 48 (fetched word) and vga_valid, output, 1 (one-cycle fetch-complete pulse).
REQ-007 SHALL have ports vga_offset_sel, input, 1 (VGA frame-boundary strobe) and vga_offset, output, 20 (active frame base offset).
REQ-008 SHALL have ports cpu_req, input, 1; cpu_we, input, 1; cpu_addr, input, 20; cpu_wdata, input, 48: CPU request, level.
REQ-009 SHALL have ports cpu_rdata, output, 48 and cpu_ack, output, 1 (one-cycle completion pulse).
REQ-010 SHALL have ports mem_req, output, 1; mem_we, output, 1; mem_addr, output, 20; mem_wdata, output, 48: memory request.
REQ-011 SHALL have ports mem_rdata, input, 48 and mem_ack, input, 1 (one-cycle completion pulse, rdata valid with it).

Function
REQ-012 SHALL implement FSM states IDLE, VGA_XFER, CPU_XFER, CPU_REG.
- IDLE: no request -> IDLE; select per REQ-013; cpu_req with cpu_addr==OFFSET_ADDR -> CPU_REG.
- VGA_XFER/CPU_XFER -> IDLE on the cycle after mem_ack.
- CPU_REG -> IDLE after one cycle.
REQ-013 Arbitration in IDLE: VGA wins when vga_sel=1 and run counter < VGA_MAX_RUN; otherwise CPU wins if cpu_req=1; otherwise VGA if vga_sel=1.
REQ-014 Run counter: +1 on each VGA grant while cpu_req=1, saturates at VGA_MAX_RUN; cleared on any CPU grant or when cpu_req=0 in IDLE.
REQ-015 On a grant, mem_addr/mem_we/mem_wdata SHALL be registered from the winner; mem_req=1 from the next cycle, held with stable payload until the cycle mem_ack=1, then dropped the following cycle.
REQ-016 VGA grants SHALL drive mem_we=0; VGA writes are not supported.
REQ-017 On mem_ack in VGA_XFER: vga_data<=mem_rdata and vga_valid=1 for exactly one cycle; in CPU_XFER: cpu_rdata<=mem_rdata (reads only; unchanged on writes) and cpu_ack=1 for one cycle.
REQ-018 Latency: requester pulse no earlier than 2 cycles after grant for zero-wait memory (grant, mem_req, mem_ack same cycle, pulse next).
REQ-019 A requester SHALL NOT be regranted in the cycle its pulse is asserted; arbitration resumes from IDLE the cycle after.
REQ-020 CPU_REG: write loads offset_shadow<=cpu_wdata[19:0]; read returns {28'b0, offset_shadow}; cpu_ack=1 one cycle after grant; mem_req stays 0.
REQ-021 vga_offset SHALL update from offset_shadow only on the cycle after vga_offset_sel=1, never mid-frame.
REQ-022 Simultaneous CPU_REG write and vga_offset_sel: vga_offset takes the pre-write shadow value.
REQ-023 Requester dropping sel/req while granted SHALL NOT abort the transfer; the transfer completes and its pulse is still issued.
REQ-024 mem_ack while in IDLE or CPU_REG SHALL be ignored.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, run counter=0, offset_shadow=0, vga_offset=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_valid=0, vga_data=0, cpu_ack=0, cpu_rdata=0.
REQ-026 Reset mid-transfer SHALL abandon the transfer with no pulse issued; a later mem_ack is ignored per REQ-024.

Verification
REQ-027 VGA read: vga_sel=1, vga_addr=20'h00123, memory acks 3 cycles later with 48'hA5A5_0000_1234 -> vga_valid one cycle, vga_data=48'hA5A5_0000_1234, mem_we=0.
REQ-028 Starvation guard: vga_sel and cpu_req held high, VGA_MAX_RUN=4 -> grant order V,V,V,V,C,V,... with cpu_ack after the 4th vga_valid.
REQ-029 Offset register: CPU write 48'h0_0004_B000 to 20'hFFFFF -> cpu_ack, mem_req never asserted; vga_offset stays 0 until vga_offset_sel pulse, then 20'h4B000.
REQ-030 CPU write: cpu_we=1, cpu_addr=20'h00040, cpu_wdata=48'h1 -> mem_we=1, mem_addr=20'h00040, mem_wdata=48'h1 held until mem_ack; cpu_ack once; cpu_rdata unchanged.
REQ-031 Reset during VGA_XFER with mem_req=1 -> all outputs 0 immediately; subsequent stale mem_ack produces no vga_valid.
